motor_dir_sequencer: RTL and testbench

Command-driven sequencer for the two-bit motor direction decoder that drives the left/right H-bridge inputs. It accepts timed motion commands over a valid/ready handshake and drives the decoder's direction code plus a bridge enable. It inserts a fixed dead-time, with both bridges disabled, on every direction change and at the end of every move, so no H-bridge leg ever switches polarity while driven. It sits between the motion-command source and the direction decoder.

---
 rtl/motor_pkg.sv | 8 +
 rtl/motor_tick_div.sv | 18 +
 rtl/motor_dir_sequencer.sv | 106 ++++++++++
 tb/tb_motor_dir_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: direction codes and sequencer state encoding shared by the motor blocks
package motor_pkg;
  localparam logic [1:0] DIR_SPIN_R = 2'd0;
  localparam logic [1:0] DIR_SPIN_L = 2'd1;
  localparam logic [1:0] DIR_FWD = 2'd2;
  localparam logic [1:0] DIR_REV = 2'd3;
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
endpackage

// File: rtl/motor_tick_div.sv
// motor_tick_div: prescaler emitting a one-cycle tick every DIV enabled cycles
module motor_tick_div #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  assign tick = en & (cnt == LAST);
  always_ff @(posedge clk)
    if (!reset_n || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/motor_dir_sequencer.sv
// motor_dir_sequencer: timed direction commands to the H-bridge decoder with dead-time
// between drive periods so no bridge leg switches polarity while driven
module motor_dir_sequencer
  import motor_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int DEADTIME = 500,
  parameter int DUR_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_dir,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             stop,
  output logic [1:0]       dir_code,
  output logic             drive_en,
  output logic             busy,
  output logic             done
);
  localparam int DW = DEADTIME > 1 ? $clog2(DEADTIME) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEADTIME - 1);
  state_t state;
  logic [DUR_W-1:0] remaining, pend_dur;
  logic [1:0] pend_dir;
  logic pend;
  logic [DW-1:0] dcnt;
  logic accept, zero_dur, reload, tick;
  assign cmd_ready = reset_n & ~stop & (state != DEAD);
  assign accept = cmd_valid & cmd_ready;
  assign zero_dur = cmd_dur == '0;
  assign reload = accept & (state == RUN) & ~zero_dur & (cmd_dir == dir_code);
  assign busy = state != IDLE;
  motor_tick_div #(.DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset_n(reset_n),
    .clr(state != RUN || reload),
    .en(state == RUN),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      dir_code <= DIR_SPIN_R;
      drive_en <= 1'b0;
      done <= 1'b0;
      pend <= 1'b0;
      pend_dir <= '0;
      pend_dur <= '0;
      remaining <= '0;
      dcnt <= '0;
    end else begin
      done <= 1'b0;
      dcnt <= '0;
      case (state)
        IDLE: if (accept) begin
          if (zero_dur) done <= 1'b1;
          else begin
            state <= RUN;
            dir_code <= cmd_dir;
            remaining <= cmd_dur;
            drive_en <= 1'b1;
          end
        end
        RUN: if (stop) begin
          state <= DEAD;
          drive_en <= 1'b0;
          pend <= 1'b0;
        end else if (accept && zero_dur) begin
          state <= DEAD;
          drive_en <= 1'b0;
          pend <= 1'b0;
          done <= 1'b1;
        end else if (reload) remaining <= cmd_dur;
        else if (accept) begin
          // direction change: park it until the dead-time has elapsed
          state <= DEAD;
          drive_en <= 1'b0;
          pend <= 1'b1;
          pend_dir <= cmd_dir;
          pend_dur <= cmd_dur;
        end else if (tick) begin
          remaining <= remaining - DUR_W'(1);
          if (remaining == DUR_W'(1)) begin
            state <= DEAD;
            drive_en <= 1'b0;
            pend <= 1'b0;
            done <= 1'b1;
          end
        end
        default: begin
          if (stop) pend <= 1'b0;
          if (dcnt != DLAST) dcnt <= dcnt + DW'(1);
          else if (pend && !stop) begin
            state <= RUN;
            dir_code <= pend_dir;
            remaining <= pend_dur;
            drive_en <= 1'b1;
            pend <= 1'b0;
          end else state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_motor_dir_sequencer.sv
// tb_motor_dir_sequencer: randomized command scenarios scored against expected drive segments
module tb_motor_dir_sequencer;
  localparam int TD = 4, DT = 3, DUR_W = 16;
  logic clk = 0, reset_n = 0, cmd_valid = 0, stop = 0;
  logic [1:0] cmd_dir = '0;
  logic [DUR_W-1:0] cmd_dur = '0;
  logic cmd_ready, drive_en, busy, done;
  logic [1:0] dir_code;
  int checks = 0, failures = 0;
  typedef struct packed {int kind; int dir; int len; int dn; int dead; int resumed;} ev_t;
  ev_t exp_q[$];
  bit mon_en = 0;
  always #5 clk = ~clk;
  motor_dir_sequencer #(.TICK_DIV(TD), .DEADTIME(DT), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_dur(cmd_dur), .stop(stop), .dir_code(dir_code),
    .drive_en(drive_en), .busy(busy), .done(done)
  );
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  function automatic ev_t mk(int k, int d, int l, int dn, int dd, int r);
    ev_t e;
    e.kind = k; e.dir = d; e.len = l; e.dn = dn; e.dead = dd; e.resumed = r;
    return e;
  endfunction
  // a drive segment: direction, high cycles, done at the fall, dead cycles, resumed into RUN
  function automatic void exp_seg(int d, int len, int dn, int res);
    exp_q.push_back(mk(0, d, len, dn, DT, res));
  endfunction
  function automatic void observe(ev_t o);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event_unexpected actual kind=%0d dir=%0d len=%0d done=%0d dead=%0d resumed=%0d required none",
               o.kind, o.dir, o.len, o.dn, o.dead, o.resumed);
    end else begin
      e = exp_q.pop_front();
      if (o != e) begin
        failures++;
        $display("FAIL event actual kind=%0d dir=%0d len=%0d done=%0d dead=%0d resumed=%0d required kind=%0d dir=%0d len=%0d done=%0d dead=%0d resumed=%0d",
                 o.kind, o.dir, o.len, o.dn, o.dead, o.resumed, e.kind, e.dir, e.len, e.dn, e.dead, e.resumed);
      end
    end
  endfunction
  bit prev_drive = 0, in_dead = 0;
  int seg_dir, seg_len, seg_done, dead_cnt;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_drive = 0;
      in_dead = 0;
    end else begin
      if (drive_en) begin
        if (in_dead) begin
          observe(mk(0, seg_dir, seg_len, seg_done, dead_cnt, 1));
          in_dead = 0;
        end
        if (!prev_drive) begin
          seg_dir = int'(dir_code);
          seg_len = 0;
        end
        seg_len++;
        if (int'(dir_code) != seg_dir) seg_dir = 9;
        if (done) observe(mk(2, 0, 0, 1, 0, 0));
      end else begin
        if (prev_drive) begin
          in_dead = 1;
          dead_cnt = 0;
          seg_done = int'(done);
        end else if (done) observe(mk(1, 0, 0, 1, 0, 0));
        if (in_dead && !busy) begin
          observe(mk(0, seg_dir, seg_len, seg_done, dead_cnt, 0));
          in_dead = 0;
        end
        if (in_dead) begin
          dead_cnt++;
          if (int'(dir_code) != seg_dir) seg_dir = 9;
        end
      end
      prev_drive = drive_en;
    end
  end
  task automatic send(input int d, input int dur, output int waited);
    cmd_valid = 1; cmd_dir = 2'(d); cmd_dur = DUR_W'(dur); waited = 0;
    #1;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    check("send_ready", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk); n++;
    end
    check({name, "_idle"}, int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int w;
    cmd_valid = 1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_drive_en", int'(drive_en), 0);
    check("rst_dir_code", int'(dir_code), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    cmd_valid = 0;
    reset_n = 1;
    @(negedge clk);
    check("idle_cmd_ready", int'(cmd_ready), 1);
    mon_en = 1;
    for (int it = 0; it < 42; it++) begin
      int sc, d, d2, d1n, d2n, k, j;
      sc = it < 7 ? it : int'($urandom_range(0, 6));
      d = $urandom_range(0, 3);
      d2 = (d + int'($urandom_range(1, 3))) % 4;
      d1n = $urandom_range(1, 4);
      d2n = $urandom_range(1, 4);
      case (sc)
        0: begin
          exp_seg(d, TD * d1n, 1, 0);
          send(d, d1n, w);
          wait_idle("single");
        end
        1: begin
          k = $urandom_range(1, TD * d1n - 1);
          exp_seg(d, k + TD * d2n, 1, 0);
          send(d, d1n, w);
          repeat (k - 1) @(negedge clk);
          send(d, d2n, w);
          wait_idle("reload");
        end
        2: begin
          k = $urandom_range(1, TD * d1n);
          exp_seg(d, k, 0, 1);
          exp_seg(d2, TD * d2n, 1, 0);
          send(d, d1n, w);
          repeat (k - 1) @(negedge clk);
          send(d2, d2n, w);
          wait_idle("dirchg");
        end
        3: begin
          k = $urandom_range(1, TD * d1n);
          exp_seg(d, k, 0, 0);
          send(d, d1n, w);
          repeat (k - 1) @(negedge clk);
          stop = 1;
          @(negedge clk);
          stop = 0;
          wait_idle("stop_run");
        end
        4: begin
          k = $urandom_range(1, TD * d1n);
          j = $urandom_range(0, DT - 1);
          exp_seg(d, k, 0, 0);
          send(d, d1n, w);
          repeat (k - 1) @(negedge clk);
          send(d2, d2n, w);
          repeat (j) @(negedge clk);
          stop = 1;
          @(negedge clk);
          stop = 0;
          wait_idle("stop_dead");
        end
        5: begin
          if (d2n % 2 == 0) begin
            exp_q.push_back(mk(1, 0, 0, 1, 0, 0));
            send(d, 0, w);
            check("zero_done_next", int'(done), 1);
            check("zero_no_drive", int'(drive_en), 0);
            wait_idle("zero_idle");
          end else begin
            k = $urandom_range(1, TD * d1n);
            exp_seg(d, k, 1, 0);
            send(d, d1n, w);
            repeat (k - 1) @(negedge clk);
            send(d, 0, w);
            wait_idle("zero_run");
          end
        end
        default: begin
          exp_seg(d, TD * d1n, 1, 0);
          exp_seg(d2, TD * d2n, 1, 0);
          send(d, d1n, w);
          for (int n = 0; drive_en && n < 100; n++) @(negedge clk);
          send(d2, d2n, w);
          check("dead_hold_wait", w, DT);
          wait_idle("held");
        end
      endcase
    end
    check("queue_drain", exp_q.size(), 0);
    mon_en = 0;
    send(3, 3, w);
    repeat (3) @(negedge clk);
    check("pre_rst_drive", int'(drive_en), 1);
    check("pre_rst_dir", int'(dir_code), 3);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    check("midrst_drive_en", int'(drive_en), 0);
    check("midrst_dir_code", int'(dir_code), 0);
    check("midrst_busy", int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
